// File: rtl/count_check_pkg.sv
// Shared definitions for the stride counter and its consumer-side checker.
package count_check_pkg;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      SYNC    = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int unsigned DEF_INC   = 4;
   localparam int unsigned DEF_WIDTH = 32;

endpackage

// File: rtl/count_checker.sv
// Stride monitor for a free-running counter: locks after LOCK good steps, then
// flags stride faults and wrap events as registered pulses with a saturating tally.
module count_checker
   import count_check_pkg::*;
#(
   parameter int unsigned      WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] INC   = WIDTH'(DEF_INC),
   parameter int unsigned      LOCK  = 2,
   parameter int unsigned      ERRW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] expected,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [ERRW-1:0]  err_count
);

   localparam int unsigned GW = $clog2(LOCK + 1);

   state_t           state;
   logic [GW-1:0]    good_run;
   logic             miss_count;
   logic [WIDTH-1:0] next_val;
   logic             carry;
   logic             match;

   function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
      return (v == '1) ? v : v + ERRW'(1);
   endfunction

   always_comb begin
      next_val = count + INC;
      carry    = (next_val < count);
      match    = (count == expected);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ACQUIRE;
         expected   <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         err_count  <= '0;
         good_run   <= '0;
         miss_count <= 1'b0;
      end else begin
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         if (en) begin
            // On a match count+INC equals expected+INC, so every enabled sample reloads from count.
            expected <= next_val;
            case (state)
               ACQUIRE: begin
                  good_run <= '0;
                  state    <= SYNC;
               end
               SYNC: begin
                  if (match) begin
                     wrap_pulse <= carry;
                     good_run   <= good_run + GW'(1);
                     if (good_run == GW'(LOCK - 1)) begin
                        state      <= LOCKED;
                        locked     <= 1'b1;
                        miss_count <= 1'b0;
                     end
                  end else begin
                     good_run <= '0;
                  end
               end
               LOCKED: begin
                  if (match) begin
                     wrap_pulse <= carry;
                     miss_count <= 1'b0;
                  end else begin
                     err_pulse <= 1'b1;
                     err_count <= sat_inc(err_count);
                     if (miss_count) begin
                        state      <= SYNC;
                        locked     <= 1'b0;
                        good_run   <= '0;
                        miss_count <= 1'b0;
                     end else begin
                        miss_count <= 1'b1;
                     end
                  end
               end
               default: begin
                  state  <= ACQUIRE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: constant vector table, randomized run against a
// rule-level reference model, and hand sequences for saturation and 8-bit wrap.
module tb_count_checker;
   import count_check_pkg::*;

   localparam int unsigned LOCK = 2;
   localparam int unsigned ERRW = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [31:0] cnt;
   logic [31:0] expected;
   logic        locked, err_pulse, wrap_pulse;
   logic [7:0]  err_count;

   logic        rst8, en8;
   logic [7:0]  cnt8;
   logic [7:0]  expected8;
   logic        locked8, err_pulse8, wrap_pulse8;
   logic [7:0]  err_count8;

   count_checker #(.WIDTH(32), .INC(32'd4), .LOCK(LOCK), .ERRW(ERRW)) dut (
      .clk(clk), .reset(rst), .en(en), .count(cnt),
      .expected(expected), .locked(locked), .err_pulse(err_pulse),
      .wrap_pulse(wrap_pulse), .err_count(err_count)
   );

   count_checker #(.WIDTH(8), .INC(8'd4), .LOCK(LOCK), .ERRW(ERRW)) dut8 (
      .clk(clk), .reset(rst8), .en(en8), .count(cnt8),
      .expected(expected8), .locked(locked8), .err_pulse(err_pulse8),
      .wrap_pulse(wrap_pulse8), .err_count(err_count8)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: prediction, streak of good steps, consecutive misses, tally.
   bit     m_acq;
   longint m_pred;
   int     m_streak, m_miss, m_errs;
   bit     m_locked, m_errp, m_wrapp;

   function automatic void model(input bit r, input bit e, input longint c);
      bit good;
      m_errp  = 1'b0;
      m_wrapp = 1'b0;
      if (r) begin
         m_acq = 0; m_pred = 0; m_streak = 0; m_miss = 0; m_errs = 0; m_locked = 0;
         return;
      end
      if (!e) return;
      good = m_acq && (c == m_pred);
      if (m_acq && m_locked && !good) begin
         m_errp = 1'b1;
         m_errs = (m_errs < 255) ? m_errs + 1 : 255;
         m_miss++;
         if (m_miss == 2) begin
            m_locked = 0; m_streak = 0; m_miss = 0;
         end
      end else if (good) begin
         m_wrapp = (c + 4) >= 64'h1_0000_0000;
         m_miss  = 0;
         if (!m_locked) begin
            m_streak++;
            if (m_streak >= LOCK) m_locked = 1;
         end
      end else begin
         m_streak = 0;
      end
      m_acq  = 1;
      m_pred = (c + 4) % 64'h1_0000_0000;
   endfunction

   task automatic step(input bit r, input bit e, input logic [31:0] c);
      rst = r; en = e; cnt = c;
      @(posedge clk);
      model(r, e, longint'(c));
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".expected"},   expected,   m_pred[31:0]);
      check({tag, ".locked"},     locked,     m_locked);
      check({tag, ".err_pulse"},  err_pulse,  m_errp);
      check({tag, ".wrap_pulse"}, wrap_pulse, m_wrapp);
      check({tag, ".err_count"},  err_count,  m_errs);
   endtask

   task automatic step8(input bit r, input bit e, input logic [7:0] c);
      rst8 = r; en8 = e; cnt8 = c;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          r;
      bit          e;
      logic [31:0] c;
      logic [31:0] x_exp;
      bit          x_lk;
      bit          x_ep;
      bit          x_wp;
      int          x_ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input bit r, input bit e, input logic [31:0] c,
                             input logic [31:0] x, input bit lk, input bit ep,
                             input bit wp, input int ec);
      vec_t t;
      t.r = r; t.e = e; t.c = c; t.x_exp = x; t.x_lk = lk; t.x_ep = ep; t.x_wp = wp; t.x_ec = ec;
      tbl.push_back(t);
   endfunction

   initial begin
      logic [31:0] cur;
      logic [31:0] s;
      bit          r, e;
      rst = 1'b1; en = 1'b0; cnt = '0;
      rst8 = 1'b1; en8 = 1'b0; cnt8 = '0;

      // reset, lock on 0,4,8, single fault, double fault and relock
      v(1, 0, 0,   0,   0, 0, 0, 0);
      v(0, 1, 0,   4,   0, 0, 0, 0);
      v(0, 1, 4,   8,   0, 0, 0, 0);
      v(0, 1, 8,   12,  1, 0, 0, 0);
      v(0, 1, 12,  16,  1, 0, 0, 0);
      v(0, 1, 16,  20,  1, 0, 0, 0);
      v(0, 1, 20,  24,  1, 0, 0, 0);
      v(0, 1, 100, 104, 1, 1, 0, 1);
      v(0, 1, 104, 108, 1, 0, 0, 1);
      v(0, 0, 999, 108, 1, 0, 0, 1);
      v(0, 1, 108, 112, 1, 0, 0, 1);
      v(0, 1, 50,  54,  1, 1, 0, 2);
      v(0, 1, 77,  81,  0, 1, 0, 3);
      v(0, 1, 81,  85,  0, 0, 0, 3);
      v(0, 1, 85,  89,  1, 0, 0, 3);
      v(0, 1, 89,  93,  1, 0, 0, 3);
      // en toggling: hold during gaps, lock after 3 enabled samples
      v(1, 0, 0,   0,   0, 0, 0, 0);
      v(0, 1, 200, 204, 0, 0, 0, 0);
      v(0, 0, 204, 204, 0, 0, 0, 0);
      v(0, 1, 204, 208, 0, 0, 0, 0);
      v(0, 0, 208, 208, 0, 0, 0, 0);
      v(0, 1, 208, 212, 1, 0, 0, 0);
      v(0, 0, 212, 212, 1, 0, 0, 0);
      // five isolated faults, then reset mid-operation
      v(0, 1, 500, 504, 1, 1, 0, 1);
      v(0, 1, 504, 508, 1, 0, 0, 1);
      v(0, 1, 600, 604, 1, 1, 0, 2);
      v(0, 1, 604, 608, 1, 0, 0, 2);
      v(0, 1, 700, 704, 1, 1, 0, 3);
      v(0, 1, 704, 708, 1, 0, 0, 3);
      v(0, 1, 800, 804, 1, 1, 0, 4);
      v(0, 1, 804, 808, 1, 0, 0, 4);
      v(0, 1, 900, 904, 1, 1, 0, 5);
      v(0, 1, 904, 908, 1, 0, 0, 5);
      v(1, 1, 908, 0,   0, 0, 0, 0);
      v(0, 1, 0,   4,   0, 0, 0, 0);
      // silent resync in SYNC, then wrap on a matching step before lock
      v(0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0, 0);
      v(0, 1, 32'hFFFF_FFFC, 0,             0, 0, 1, 0);
      v(0, 1, 0,             4,             1, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].c);
         check($sformatf("vec%0d.expected", i),   expected,   tbl[i].x_exp);
         check($sformatf("vec%0d.locked", i),     locked,     tbl[i].x_lk);
         check($sformatf("vec%0d.err_pulse", i),  err_pulse,  tbl[i].x_ep);
         check($sformatf("vec%0d.wrap_pulse", i), wrap_pulse, tbl[i].x_wp);
         check($sformatf("vec%0d.err_count", i),  err_count,  tbl[i].x_ec);
      end

      // randomized stream with faults, gaps, jumps near wrap and occasional reset
      step(1, 0, 0);
      cur = 32'd0;
      for (int i = 0; i < 800; i++) begin
         r = ($urandom % 100) == 0;
         e = ($urandom % 4) != 0;
         if (($urandom % 60) == 0) cur = 32'hFFFF_FFE0;
         s = cur;
         if (($urandom % 12) == 0) s = $urandom;
         step(r, e, s);
         check_model("rand");
         if (e && !r) cur = s + 32'd4;
      end

      // saturation: 2^ERRW+3 isolated faults, each followed by a realigned good step
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 4);
      step(0, 1, 8);
      check("sat.lock", locked, 1'b1);
      for (int i = 0; i < 259; i++) begin
         s = 32'd10000 + 32'(16 * i);
         step(0, 1, s);
         check("sat.err_pulse", err_pulse, 1'b1);
         check_model("sat");
         step(0, 1, s + 32'd4);
         check("sat.locked", locked, 1'b1);
      end
      check("sat.final", err_count, 8'd255);
      step(0, 0, 0);

      // 8-bit wrap: pulse only on the sample whose successor wraps to 0
      step8(1, 0, 0);
      check("w8.reset", expected8, 8'd0);
      step8(0, 1, 240);
      step8(0, 1, 244);
      step8(0, 1, 248);
      check("w8.locked", locked8, 1'b1);
      check("w8.wrap_pre", wrap_pulse8, 1'b0);
      step8(0, 1, 252);
      check("w8.wrap", wrap_pulse8, 1'b1);
      check("w8.no_err", err_pulse8, 1'b0);
      check("w8.exp0", expected8, 8'd0);
      step8(0, 1, 0);
      check("w8.wrap_post", wrap_pulse8, 1'b0);
      check("w8.exp4", expected8, 8'd4);
      step8(0, 1, 4);
      check("w8.exp8", expected8, 8'd8);
      check("w8.errs", err_count8, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Consumer-side monitor for the free-running stride counter. Samples the counter's `count` bus and confirms that each enabled sample advances by exactly INC, modulo 2^WIDTH.
- Locks after a run of good steps, then flags stride faults and wrap-around events.
- Reports fault and wrap events as registered pulses and keeps a saturating error tally.
- Sits beside the counter in simulation benches and in on-chip self-check logic. It consumes the counter's bus and drives nothing back.

Parameters:
- WIDTH, 32: width of the `count` bus being checked.
- INC, 4: expected stride per enabled sample. Must be nonzero and less than 2^WIDTH.
- LOCK, 2: number of consecutive matching steps required to assert `locked`. Must be at least 1.
- ERRW, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; `count` is evaluated only in cycles where en=1.
- count  input  WIDTH  value under check, from the counter.
- expected  output  WIDTH  next value the checker predicts.
- locked  output  1  high while in the LOCKED state.
- err_pulse  output  1  one-cycle pulse on a stride mismatch while locked.
- wrap_pulse  output  1  one-cycle pulse on a correct step that wrapped past 2^WIDTH.
- err_count  output  ERRW  saturating count of mismatches seen while locked.

Behaviour:
- Reset: synchronous and active-high, sampled on the rising clk edge. In the cycle after reset is seen high, all of the following are 0: `expected`, `locked`, `err_pulse`, `wrap_pulse`, `err_count`, the good-run counter and the miss counter. State becomes ACQUIRE. Reset overrides `en` and takes effect mid-operation with no draining.
- Timing: all outputs are registered. A sample taken at edge N is reflected on the outputs after edge N (latency 1). There is no combinational path from input to output.
- en=0: state, `expected` and counters hold. `err_pulse` and `wrap_pulse` deassert.
- Pulses: `err_pulse` and `wrap_pulse` are single-cycle and mutually exclusive. They are cleared in every cycle where no event occurs.
- Arithmetic: `expected` is computed as count+INC truncated to WIDTH bits. Wrap is detected when the truncated sum is less than the operand (carry out).
- State ACQUIRE (after reset): on en, set `expected` to count+INC, set good-run to 0, go to SYNC. No error is counted.
- State SYNC, on en:
  - Match (count==expected): good-run is incremented and `expected` advances by INC. When good-run reaches LOCK, go to LOCKED and assert `locked`.
  - Mismatch: silent resync. Set `expected` to count+INC and good-run to 0. No error pulse and no error count.
  - Wrap on a matching step: `wrap_pulse` fires.
- State LOCKED, on en:
  - Match: `expected` advances by INC and the miss counter clears. `wrap_pulse` fires if the step wrapped.
  - Mismatch: `err_pulse` fires and `err_count` increments, saturating at 2^ERRW-1. `expected` realigns to count+INC and the miss counter increments.
  - Second consecutive mismatch: go to SYNC, deassert `locked` and clear good-run. `err_pulse` still fires for this sample.
- LOCK=1: lock is reached on the first matching step after ACQUIRE.
- Gaps in `en` are not errors. The checker predicts per sample, not per cycle.

Decomposition:
- Shared package `count_check_pkg` holds:
  - the state encoding: ACQUIRE=2'd0, SYNC=2'd1, LOCKED=2'd2;
  - default constants DEF_INC=4 and DEF_WIDTH=32, shared with the counter and its bench.
- No sub-module is required. A single always block holds the FSM and datapath, and the saturating add is a local function.
- Paired bench `count_checker_tb` instantiates `counter` with INC=4 and wires its `count` output into this block.

Test Plan:
1. Counter with INC=4 starting at 0, en=1, after reset deasserts:
   - Samples are 0, 4, 8. `locked`=1 after the sample 8 edge, and `expected`=12.
   - `err_count` stays 0 for 20 cycles.
2. While locked at `expected`=24, force count=100 for one sample, then resume the stride from 104:
   - `err_pulse`=1 for one cycle, `err_count`=1, `locked` stays 1.
   - Next step 104→108 matches.
3. While locked, inject two consecutive bad samples (50, then 77):
   - `err_count` increments by 2 and `locked` falls after the second sample.
   - Relock after LOCK good steps from 77: 81, 85.
4. WIDTH=8, INC=4, count stepping ..., 248, 252, 0, 4:
   - `wrap_pulse`=1 exactly on the 252→0 sample, with no `err_pulse`.
   - `expected`=8 afterwards.
5. Toggle en every other cycle with the counter advancing only on enabled cycles:
   - No errors; `locked` after 3 enabled samples.
   - Outputs hold during en=0.
6. Assert reset for one cycle while locked with `err_count`=5:
   - Next cycle all outputs are 0 and state is ACQUIRE.
   - Force 2^ERRW+3 mismatches: `err_count` saturates at 255 for ERRW=8.
